// File: rtl/lfu_counter_bank_if.sv
// Lookup / update / flush bundle between the cache controller and the
// LFU counter bank.
//   master : requester side (cache controller)
//   slave  : counter bank side
// Signals
//   lu_valid/lu_ready/lu_set     lookup handshake and set index
//   cnt_valid, count0..count3    registered counters of the looked-up set
//   up_valid/up_ready/up_set     update handshake and set index
//   up_way, up_hit               target way; 1=hit (increment), 0=fill
//   flush, flush_busy            flush pulse and flush-walk status
interface lfu_counter_bank_if #(
   parameter int SETS         = 16,
   parameter int SET_W        = $clog2(SETS),
   parameter int SIZE_COUNTER = 4
);
   logic                    lu_valid;
   logic                    lu_ready;
   logic [SET_W-1:0]        lu_set;
   logic                    cnt_valid;
   logic [SIZE_COUNTER-1:0] count0;
   logic [SIZE_COUNTER-1:0] count1;
   logic [SIZE_COUNTER-1:0] count2;
   logic [SIZE_COUNTER-1:0] count3;
   logic                    up_valid;
   logic                    up_ready;
   logic [SET_W-1:0]        up_set;
   logic [1:0]              up_way;
   logic                    up_hit;
   logic                    flush;
   logic                    flush_busy;

   modport master (
      output lu_valid, lu_set, up_valid, up_set, up_way, up_hit, flush,
      input  lu_ready, cnt_valid, count0, count1, count2, count3,
             up_ready, flush_busy
   );

   modport slave (
      input  lu_valid, lu_set, up_valid, up_set, up_way, up_hit, flush,
      output lu_ready, cnt_valid, count0, count1, count2, count3,
             up_ready, flush_busy
   );
endinterface

// File: rtl/lfu_counter_bank.sv
// Per-set, per-way access-frequency counters for a 4-way LFU cache.
// Lookups return the four counters of a set one cycle after accept; updates
// increment on hit or restart at 1 on fill. A hit on a saturated counter
// ages the whole set (halve all, target gets CMAX/2+1) in one extra cycle.
// A flush pulse walks all sets clearing one per cycle.
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    lfu_counter_bank_if.slave (lookup, update, flush signals)
module lfu_counter_bank #(
   parameter int SETS         = 16,
   parameter int SET_W        = $clog2(SETS),
   parameter int SIZE_COUNTER = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   lfu_counter_bank_if.slave   bus
);

   localparam logic [SIZE_COUNTER-1:0] CMAX    = '1;
   localparam logic [SIZE_COUNTER-1:0] ONE     = SIZE_COUNTER'(1);
   localparam logic [SIZE_COUNTER-1:0] AGE_VAL = (CMAX >> 1) + ONE;
   localparam logic [SET_W-1:0]        LAST    = SET_W'(SETS - 1);

   typedef enum logic [1:0] {IDLE, AGE, FLUSH} state_t;

   state_t                  state, state_nx;
   logic [SIZE_COUNTER-1:0] cnt [SETS][4];
   logic [SIZE_COUNTER-1:0] count_p1 [4];
   logic                    cnt_valid_p1;
   logic [SET_W-1:0]        age_set;
   logic [1:0]              age_way;
   logic [SET_W-1:0]        flush_idx;
   logic                    lu_acc;
   logic                    up_acc;
   logic                    sat_hit;

   function automatic logic [SIZE_COUNTER-1:0] inc_count(
      input logic [SIZE_COUNTER-1:0] v);
      // Only called below CMAX; saturation is routed through AGE instead.
      return v + ONE;
   endfunction

   function automatic logic [SIZE_COUNTER-1:0] age_count(
      input logic [SIZE_COUNTER-1:0] v, input logic is_target);
      return is_target ? AGE_VAL : (v >> 1);
   endfunction

   // Handshake outputs are pure state decodes.
   assign bus.lu_ready   = (state == IDLE);
   assign bus.up_ready   = (state == IDLE);
   assign bus.flush_busy = (state == FLUSH);

   // A flush pulse in the same cycle drops any lookup/update being accepted.
   assign lu_acc  = bus.lu_valid && bus.lu_ready && !bus.flush;
   assign up_acc  = bus.up_valid && bus.up_ready && !bus.flush;
   assign sat_hit = up_acc && bus.up_hit && (cnt[bus.up_set][bus.up_way] == CMAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (bus.flush)    state_nx = FLUSH;
            else if (sat_hit) state_nx = AGE;
         end
         AGE: begin
            if (bus.flush) state_nx = FLUSH;
            else           state_nx = IDLE;
         end
         FLUSH: begin
            if (flush_idx == LAST) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Flush walk index: held at 0 outside FLUSH, so it always starts at set 0
   // and wraps back to 0 after the last set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              flush_idx <= '0;
      else if (state == FLUSH) flush_idx <= flush_idx + SET_W'(1);
      else                     flush_idx <= '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         age_set <= '0;
         age_way <= '0;
      end else if (sat_hit) begin
         age_set <= bus.up_set;
         age_way <= bus.up_way;
      end
   end

   // Counter storage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < SETS; s++)
            for (int w = 0; w < 4; w++)
               cnt[s][w] <= '0;
      end else begin
         case (state)
            FLUSH: begin
               for (int w = 0; w < 4; w++)
                  cnt[flush_idx][w] <= '0;
            end
            AGE: begin
               // A flush arriving during AGE abandons the aging write.
               if (!bus.flush)
                  for (int w = 0; w < 4; w++)
                     cnt[age_set][w] <= age_count(cnt[age_set][w], age_way == 2'(w));
            end
            default: begin
               if (up_acc) begin
                  if (!bus.up_hit)
                     cnt[bus.up_set][bus.up_way] <= ONE;
                  else if (cnt[bus.up_set][bus.up_way] != CMAX)
                     cnt[bus.up_set][bus.up_way] <= inc_count(cnt[bus.up_set][bus.up_way]);
               end
            end
         endcase
      end
   end

   // Lookup stage p1: registered read of the pre-update counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_valid_p1 <= 1'b0;
         for (int w = 0; w < 4; w++) count_p1[w] <= '0;
      end else begin
         cnt_valid_p1 <= lu_acc;
         if (lu_acc)
            for (int w = 0; w < 4; w++) count_p1[w] <= cnt[bus.lu_set][w];
      end
   end

   assign bus.cnt_valid = cnt_valid_p1;
   assign bus.count0    = count_p1[0];
   assign bus.count1    = count_p1[1];
   assign bus.count2    = count_p1[2];
   assign bus.count3    = count_p1[3];

endmodule

// File: tb/tb_lfu_counter_bank.sv
// Directed testbench for lfu_counter_bank (SETS=16, SIZE_COUNTER=4).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_lfu_counter_bank;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   lfu_counter_bank_if #(.SETS(16), .SIZE_COUNTER(4)) bus ();

   lfu_counter_bank #(.SETS(16), .SIZE_COUNTER(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] counts();
      return {bus.count0, bus.count1, bus.count2, bus.count3};
   endfunction

   task automatic lookup(input int set, input logic [15:0] exp, input string tag);
      bus.lu_valid = 1'b1;
      bus.lu_set   = 4'(set);
      @(negedge clk);
      bus.lu_valid = 1'b0;
      check({tag, "_vld"}, 32'(bus.cnt_valid), 32'd1);
      check(tag, 32'(counts()), 32'(exp));
   endtask

   task automatic update(input int set, input int way, input logic hit);
      bus.up_valid = 1'b1;
      bus.up_set   = 4'(set);
      bus.up_way   = 2'(way);
      bus.up_hit   = hit;
      @(negedge clk);
      bus.up_valid = 1'b0;
   endtask

   // Fill then (val-1) hits leaves the counter at val.
   task automatic set_way(input int set, input int way, input int val);
      if (val > 0) begin
         update(set, way, 1'b0);
         for (int i = 1; i < val; i++) update(set, way, 1'b1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bus.lu_valid = 1'b0; bus.lu_set = '0;
      bus.up_valid = 1'b0; bus.up_set = '0; bus.up_way = '0; bus.up_hit = 1'b0;
      bus.flush    = 1'b0;

      // Reset values
      repeat (2) @(negedge clk);
      check("rst_cnt_valid", 32'(bus.cnt_valid), 32'd0);
      check("rst_counts", 32'(counts()), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_lu_ready", 32'(bus.lu_ready), 32'd1);
      check("rst_up_ready", 32'(bus.up_ready), 32'd1);
      check("rst_flush_busy", 32'(bus.flush_busy), 32'd0);

      // Lookup after reset, then valid drops without a new accept
      lookup(3, 16'h0000, "lu_set3");
      @(negedge clk);
      check("lu_vld_drop", 32'(bus.cnt_valid), 32'd0);

      // Fill + 3 hits back-to-back, no stalls
      for (int i = 0; i < 4; i++) begin
         check("up_no_stall", 32'(bus.up_ready), 32'd1);
         update(5, 2, (i != 0));
      end
      lookup(5, 16'h0040, "hits_set5");
      update(5, 2, 1'b0);
      lookup(5, 16'h0010, "refill_set5");

      // Saturation and aging of set 1
      set_way(1, 0, 15);
      set_way(1, 1, 6);
      set_way(1, 2, 1);
      lookup(1, 16'hF610, "pre_age_set1");
      update(1, 0, 1'b1);
      check("age_up_ready", 32'(bus.up_ready), 32'd0);
      check("age_lu_ready", 32'(bus.lu_ready), 32'd0);
      @(negedge clk);
      check("post_age_up_ready", 32'(bus.up_ready), 32'd1);
      lookup(1, 16'h8300, "aged_set1");

      // Same-cycle lookup and hit on set 7: read-before-write
      set_way(7, 1, 2);
      bus.lu_valid = 1'b1; bus.lu_set = 4'd7;
      bus.up_valid = 1'b1; bus.up_set = 4'd7; bus.up_way = 2'd1; bus.up_hit = 1'b1;
      @(negedge clk);
      bus.lu_valid = 1'b0; bus.up_valid = 1'b0;
      check("rbw_set7", 32'(counts()), 32'h0200);
      lookup(7, 16'h0300, "after_rbw_set7");

      // Flush with same-cycle update (fill set 9) and lookup, both dropped
      bus.flush    = 1'b1;
      bus.up_valid = 1'b1; bus.up_set = 4'd9; bus.up_way = 2'd0; bus.up_hit = 1'b0;
      bus.lu_valid = 1'b1; bus.lu_set = 4'd1;
      @(negedge clk);
      bus.flush = 1'b0; bus.up_valid = 1'b0; bus.lu_valid = 1'b0;
      check("flush_drop_lu", 32'(bus.cnt_valid), 32'd0);
      n = 0;
      while (bus.flush_busy && n < 40) begin
         n++;
         bus.flush = (n == 3);       // pulse during FLUSH must be ignored
         if (bus.cnt_valid) check("flush_cnt_valid", 32'(bus.cnt_valid), 32'd0);
         @(negedge clk);
      end
      bus.flush = 1'b0;
      check("flush_busy_cycles", 32'(n), 32'd16);
      for (int s = 0; s < 16; s++) lookup(s, 16'h0000, $sformatf("flushed_set%0d", s));

      // Reset asserted mid-FLUSH
      set_way(2, 0, 1);
      lookup(2, 16'h1000, "pre_flush_set2");
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      repeat (3) @(negedge clk);
      check("midflush_busy", 32'(bus.flush_busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rstflush_busy", 32'(bus.flush_busy), 32'd0);
      check("rstflush_lu_ready", 32'(bus.lu_ready), 32'd1);
      check("rstflush_counts", 32'(counts()), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Reset asserted mid-AGE
      set_way(4, 0, 15);
      set_way(4, 3, 2);
      lookup(4, 16'hF002, "pre_age_set4");
      update(4, 0, 1'b1);
      check("midage_up_ready", 32'(bus.up_ready), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      check("rstage_up_ready", 32'(bus.up_ready), 32'd1);
      check("rstage_cnt_valid", 32'(bus.cnt_valid), 32'd0);
      check("rstage_counts", 32'(counts()), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      lookup(4, 16'h0000, "after_rst_set4");
      check("after_rst_busy", 32'(bus.flush_busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
